request_dispatcher: RTL and testbench
=====================================

REQUEST_DISPATCHER -- requirements
Module: request_dispatcher

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 32, meaning the number of request lines; only 32 is supported.
REQ-002 The block SHALL have parameter IDX_W, default 5, meaning the index width, equal to $clog2(NUM_REQ).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 The block SHALL have port req_i, input, NUM_REQ bits: request events; a 1 on bit k in any cycle sets pending bit k.
REQ-006 The block SHALL have port out_valid_o, output, 1 bit: a dispatched index is presented.
REQ-007 The block SHALL have port out_idx_o, output, IDX_W bits: the index being dispatched.
REQ-008 The block SHALL have port out_ready_i, input, 1 bit: the consumer accepts; a handshake occurs when out_valid_o && out_ready_i.
REQ-009 The block SHALL have port pending_o, output, NUM_REQ bits: the registered pending vector, excluding the in-flight bit.
REQ-010 The block SHALL have port busy_o, output, 1 bit: |pending_o || out_valid_o.

Function
REQ-011 The block SHALL form the eligible vector each cycle as eff = (pending | req_i), further AND-ed with mask when REQ_MASK_EN is defined.
REQ-012 The block SHALL select the highest set index of eff; bit 31 has the highest priority and bit 0 the lowest.
REQ-013 The output register SHALL be loaded when (!out_valid_o || out_ready_i) && |eff.
REQ-014 On load, out_idx_o SHALL take the selected index, out_valid_o SHALL go to 1, and the selected bit SHALL be cleared from pending in the same edge.
REQ-015 When a handshake occurs and no load happens, out_valid_o SHALL go to 0.
REQ-016 While out_valid_o=1 and out_ready_i=0, out_valid_o and out_idx_o SHALL hold unchanged; dispatch is non-preemptive even if a higher request arrives.
REQ-017 Latency SHALL be one cycle: req_i bit k high in cycle N with the output free SHALL give out_valid_o=1 and out_idx_o=k in cycle N+1.
REQ-018 During a sustained out_ready_i=1 with pending work, the block SHALL sustain one dispatch per cycle with no bubble.
REQ-019 A req_i pulse on a bit that is already pending SHALL be absorbed; the bit remains a single pending event and is not counted.
REQ-020 A req_i on the bit currently in flight SHALL set pending for that bit, which SHALL be redispatched later.
REQ-021 A req_i on the bit being loaded in the same cycle SHALL be consumed by that load and SHALL NOT remain pending.
REQ-022 When eff=0 and no handshake occurs, the block SHALL hold all state.

Reset
REQ-023 While rst_n=0, pending, out_valid_o and out_idx_o SHALL be 0 immediately and asynchronously, so pending_o=0 and busy_o=0.
REQ-024 A reset asserted mid-transfer SHALL discard the in-flight index and all pending events, and no handshake SHALL be reported.
REQ-025 The first load after reset SHALL occur no earlier than the first rising edge after rst_n deasserts.

Configuration
REQ-026 With macro REQ_MASK_EN defined, the block SHALL have an input port mask_i of NUM_REQ bits in which 1 means eligible.
REQ-027 With REQ_MASK_EN defined, masked bits SHALL still accumulate in pending but SHALL NOT be selected until unmasked.
REQ-028 A mask change SHALL NOT affect an index already presented on out_idx_o.
REQ-029 Without REQ_MASK_EN, mask_i SHALL be absent and all bits SHALL be eligible.

Structure
REQ-030 A shared package dispatch_pkg SHALL hold NUM_REQ_C=32 and IDX_W_C=5.
REQ-031 One combinational sub-module, prio_pick32, SHALL return the highest set index and an any-set flag for a 32-bit vector.
REQ-032 All registers SHALL reside in request_dispatcher.

Verification
REQ-033 The bench SHALL check: after reset, req_i=0x0000_0001 for 1 cycle with out_ready_i=1 -> cycle+1 gives out_valid_o=1 and out_idx_o=0, cycle+2 gives out_valid_o=0 and busy_o=0.
REQ-034 The bench SHALL check: req_i=0x8000_0011 in one cycle with out_ready_i=1 -> indices 31, 4, 0 on three consecutive cycles with no bubble.
REQ-035 The bench SHALL check: out_ready_i=0, idx 3 presented, then req_i bit 20 -> out_idx_o stays 3; after ready, the next dispatch is 20.
REQ-036 The bench SHALL check: idx 7 in flight, req_i bit 7 pulsed twice -> after handshake, idx 7 is redispatched exactly once.
REQ-037 The bench SHALL check: rst_n dropped while out_valid_o=1 and pending_o=0x0000_00F0 -> all outputs are 0 immediately.
REQ-038 The bench SHALL check, with REQ_MASK_EN defined: mask_i=0x0000_FFFF and req_i=0x0001_0002 -> dispatch 1 only, pending_o=0x0001_0000; on setting mask_i=all-ones, dispatch 16.

Source files
------------

// File: rtl/dispatch_pkg.sv
// Shared constants for the request dispatcher slice.
// Only a 32-request configuration is supported; the index width follows from it.
package dispatch_pkg;

  localparam int NUM_REQ_C = 32;
  localparam int IDX_W_C   = 5;

  // Decode a request index into its single-bit position in the request vector.
  function automatic logic [NUM_REQ_C-1:0] idx_to_onehot(input logic [IDX_W_C-1:0] idx);
    return {{(NUM_REQ_C-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/prio_pick32.sv
// Fixed-priority picker: highest set bit of a 32-bit vector wins (bit 31 first).
// Purely combinational; 'any' flags that at least one bit is set.
module prio_pick32
  import dispatch_pkg::*;
(
  input  logic [NUM_REQ_C-1:0] vec,
  output logic [IDX_W_C-1:0]   idx,
  output logic                 any
);

  // Ascending scan so the highest set bit is the last one written.
  always_comb begin
    idx = '0;
    any = |vec;
    for (int i = 0; i < NUM_REQ_C; i++) begin
      if (vec[i]) idx = i[IDX_W_C-1:0];
    end
  end

endmodule

// File: rtl/request_dispatcher.sv
// Request dispatcher: collects single-cycle request events into a pending
// vector and hands them out one index at a time over a valid/ready output,
// highest index first, one dispatch per cycle when the consumer keeps up.
// Optional feature: define REQ_MASK_EN to add mask_i; masked requests keep
// accumulating in pending but are not selected until their mask bit is set.
module request_dispatcher
  import dispatch_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_C,
  parameter int IDX_W   = IDX_W_C
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req_i,
`ifdef REQ_MASK_EN
  input  logic [NUM_REQ-1:0] mask_i,
`endif
  output logic               out_valid_o,
  output logic [IDX_W-1:0]   out_idx_o,
  input  logic               out_ready_i,
  output logic [NUM_REQ-1:0] pending_o,
  output logic               busy_o
);

  logic [NUM_REQ-1:0] pending_p1;
  logic               vld_p1;
  logic [IDX_W-1:0]   idx_p1;

  logic [NUM_REQ-1:0] merged;
  logic [NUM_REQ-1:0] eff;
  logic [IDX_W-1:0]   sel_idx;
  logic               sel_any;
  logic               load;
  logic [NUM_REQ-1:0] clr;

  // Stage p0: merge new events with pending work and pick a winner.
  always_comb begin
    merged = pending_p1 | req_i;
`ifdef REQ_MASK_EN
    eff = merged & mask_i;
`else
    eff = merged;
`endif
  end

  prio_pick32 u_pick (
    .vec (eff),
    .idx (sel_idx),
    .any (sel_any)
  );

  // Load whenever the output slot is empty or being drained this cycle.
  always_comb begin
    load = (!vld_p1 || out_ready_i) && sel_any;
    clr  = load ? idx_to_onehot(sel_idx) : '0;
  end

  // Stage p1: pending vector; a request on the bit being loaded is consumed by the load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending_p1 <= '0;
    else        pending_p1 <= merged & ~clr;
  end

  // Stage p1: output slot, held non-preemptively until the consumer accepts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      idx_p1 <= '0;
    end else if (load) begin
      vld_p1 <= 1'b1;
      idx_p1 <= sel_idx;
    end else if (vld_p1 && out_ready_i) begin
      vld_p1 <= 1'b0;
    end
  end

  assign out_valid_o = vld_p1;
  assign out_idx_o   = idx_p1;
  assign pending_o   = pending_p1;
  assign busy_o      = (|pending_p1) || vld_p1;

endmodule

// File: tb/tb_request_dispatcher.sv
// Self-checking bench for request_dispatcher: directed scenarios with fixed
// expected values, then randomized traffic against a behavioural model.
module tb_request_dispatcher;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] req_i;
  logic [31:0] mask_i;
  logic        out_valid_o;
  logic [4:0]  out_idx_o;
  logic        out_ready_i;
  logic [31:0] pending_o;
  logic        busy_o;

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model state
  bit [31:0] m_pend;
  bit        m_vld;
  int        m_idx;

  always #5 clk = ~clk;

  request_dispatcher dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_i       (req_i),
`ifdef REQ_MASK_EN
    .mask_i      (mask_i),
`endif
    .out_valid_o (out_valid_o),
    .out_idx_o   (out_idx_o),
    .out_ready_i (out_ready_i),
    .pending_o   (pending_o),
    .busy_o      (busy_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit [31:0] eff_mask();
`ifdef REQ_MASK_EN
    return mask_i;
`else
    return 32'hFFFF_FFFF;
`endif
  endfunction

  // One clock: model follows the dispatch rules, then both are compared at +1.
  task automatic tick();
    bit [31:0] all_work;
    bit [31:0] eligible;
    bit        can_load;
    int        best;
    all_work = m_pend | req_i;
    eligible = all_work & eff_mask();
    can_load = (!m_vld || out_ready_i) && (eligible != 0);
    best = -1;
    for (int k = 31; k >= 0 && best < 0; k--)
      if (eligible[k]) best = k;
    @(posedge clk);
    #1;
    if (can_load) begin
      m_vld  = 1'b1;
      m_idx  = best;
      all_work[best] = 1'b0;
    end else if (m_vld && out_ready_i) begin
      m_vld = 1'b0;
    end
    m_pend = all_work;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".vld"},  {31'd0, out_valid_o}, {31'd0, m_vld});
    if (m_vld) chk({tag, ".idx"}, {27'd0, out_idx_o}, m_idx);
    chk({tag, ".pend"}, pending_o, m_pend);
    chk({tag, ".busy"}, {31'd0, busy_o}, {31'd0, (m_pend != 0) || m_vld});
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    m_pend = '0; m_vld = 1'b0; m_idx = 0;
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    rst_n = 1'b0; req_i = '0; mask_i = '1; out_ready_i = 1'b1;
    m_pend = '0; m_vld = 1'b0; m_idx = 0;
    #12;
    chk("rst.vld",  {31'd0, out_valid_o}, 32'd0);
    chk("rst.idx",  {27'd0, out_idx_o},   32'd0);
    chk("rst.pend", pending_o,            32'd0);
    chk("rst.busy", {31'd0, busy_o},      32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Single request, one-cycle latency, then idle
    req_i = 32'h0000_0001; tick(); req_i = '0;
    chk("lat.vld", {31'd0, out_valid_o}, 32'd1);
    chk("lat.idx", {27'd0, out_idx_o},   32'd0);
    tick();
    chk("lat.vld2",  {31'd0, out_valid_o}, 32'd0);
    chk("lat.busy2", {31'd0, busy_o},      32'd0);

    // Back-to-back priority order without bubbles
    req_i = 32'h8000_0011; tick(); req_i = '0;
    chk("b2b.idx31", {26'd0, out_valid_o, out_idx_o}, 32'h3F);
    tick();
    chk("b2b.idx4",  {26'd0, out_valid_o, out_idx_o}, 32'h24);
    tick();
    chk("b2b.idx0",  {26'd0, out_valid_o, out_idx_o}, 32'h20);
    tick();
    chk("b2b.idle",  {31'd0, out_valid_o}, 32'd0);

    // Non-preemptive hold under backpressure
    out_ready_i = 1'b0;
    req_i = 32'h0000_0008; tick(); req_i = 32'h0010_0000;
    chk("hold.idx3", {26'd0, out_valid_o, out_idx_o}, 32'h23);
    tick(); req_i = '0;
    chk("hold.still3", {26'd0, out_valid_o, out_idx_o}, 32'h23);
    chk("hold.pend",   pending_o, 32'h0010_0000);
    tick();
    chk("hold.still3b", {26'd0, out_valid_o, out_idx_o}, 32'h23);
    out_ready_i = 1'b1; tick();
    chk("hold.idx20", {26'd0, out_valid_o, out_idx_o}, 32'h34);
    tick();
    chk("hold.idle",  {31'd0, out_valid_o}, 32'd0);

    // Re-request of the in-flight bit is redispatched exactly once
    out_ready_i = 1'b0;
    req_i = 32'h0000_0080; tick();
    chk("re.idx7", {26'd0, out_valid_o, out_idx_o}, 32'h27);
    tick(); req_i = '0; tick(); req_i = 32'h0000_0080; tick(); req_i = '0;
    chk("re.pend", pending_o, 32'h0000_0080);
    out_ready_i = 1'b1; tick();
    chk("re.again7", {26'd0, out_valid_o, out_idx_o}, 32'h27);
    chk("re.pend0",  pending_o, 32'd0);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("re.once", {31'd0, out_valid_o}, 32'd0);
    end

    // Asynchronous reset while a transfer is in flight
    out_ready_i = 1'b0;
    req_i = 32'h0000_01F0; tick(); req_i = '0;
    chk("ar.pre.vld",  {26'd0, out_valid_o, out_idx_o}, 32'h28);
    chk("ar.pre.pend", pending_o, 32'h0000_00F0);
    #1 rst_n = 1'b0;
    #1;
    chk("ar.vld",  {31'd0, out_valid_o}, 32'd0);
    chk("ar.idx",  {27'd0, out_idx_o},   32'd0);
    chk("ar.pend", pending_o,            32'd0);
    chk("ar.busy", {31'd0, busy_o},      32'd0);
    do_reset();
    out_ready_i = 1'b1; tick();
    chk("ar.after", {31'd0, out_valid_o}, 32'd0);

`ifdef REQ_MASK_EN
    // Masked requests wait in pending until unmasked
    mask_i = 32'h0000_FFFF;
    req_i = 32'h0001_0002; tick(); req_i = '0;
    chk("mask.idx1", {26'd0, out_valid_o, out_idx_o}, 32'h21);
    chk("mask.pend", pending_o, 32'h0001_0000);
    tick();
    chk("mask.wait", {31'd0, out_valid_o}, 32'd0);
    chk("mask.pend2", pending_o, 32'h0001_0000);
    mask_i = '1; tick();
    chk("mask.idx16", {26'd0, out_valid_o, out_idx_o}, 32'h30);
    tick();
`endif

    // Randomized traffic against the model
    for (int c = 0; c < 600; c++) begin
      case ($urandom_range(0, 3))
        0: req_i = '0;
        1: req_i = 32'd1 << $urandom_range(0, 31);
        default: req_i = $urandom & $urandom & $urandom;
      endcase
      out_ready_i = ($urandom_range(0, 9) < 7);
`ifdef REQ_MASK_EN
      if ($urandom_range(0, 7) == 0) mask_i = $urandom | $urandom;
`endif
      tick();
      chk_model("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
